// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO queue and its storage.
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  localparam int DEF_PTR_W = clog2(DEF_DEPTH);

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register file: synchronous write, asynchronous read, no reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_queue.sv
// Same-clock FIFO byte queue with occupancy count, threshold flags and
// sticky overflow/underflow; every output is registered.
module fifo_queue
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     push,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    wptr, rptr;
  logic [WIDTH-1:0] rdata;
  logic             pop_ok, push_ok;
  logic [CW-1:0]    count_next;

  // A full queue still takes a push when a pop frees a slot in the same edge.
  assign pop_ok     = pop & ~empty;
  assign push_ok    = push & (~full | pop_ok);
  assign count_next = count + CW'(push_ok) - CW'(pop_ok);

  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wptr),
    .wdata (din),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wptr         <= '0;
      rptr         <= '0;
      dout         <= '0;
      valid        <= 1'b0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      valid <= pop_ok;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
        dout <= rdata;
      end
      if (push & ~push_ok) overflow  <= 1'b1;
      if (pop & ~pop_ok)   underflow <= 1'b1;
      // Flags follow count_next so they line up with the new count.
      count        <= count_next;
      full         <= (count_next == CW'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= CW'(AF_LEVEL));
      almost_empty <= (count_next <= CW'(AE_LEVEL));
    end
  end

endmodule

// File: tb/tb_fifo_queue.sv
// Directed bench for fifo_queue with a reference queue as scoreboard.
module tb_fifo_queue;

  logic       clk, clr, push, pop;
  logic [7:0] din, dout;
  logic [3:0] count;
  logic       valid, full, empty, almost_full, almost_empty, overflow, underflow;

  int n_cmp, n_bad;
  logic [7:0] q[$];
  logic [7:0] exp_dout;
  bit         exp_ovf, exp_unf;

  fifo_queue #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk(clk), .clr(clr), .din(din), .push(push), .pop(pop),
    .dout(dout), .valid(valid), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags();
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == 8));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= 6));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_unf));
  endtask

  // One clock: predict with the scoreboard, drive, then compare after the edge.
  task automatic step(input bit ps, input bit pp, input logic [7:0] d);
    bit pop_ok, push_ok;
    pop_ok  = pp && (q.size() != 0);
    push_ok = ps && ((q.size() < 8) || pop_ok);
    if (pop_ok) exp_dout = q.pop_front();
    if (push_ok) q.push_back(d);
    if (ps && !push_ok) exp_ovf = 1'b1;
    if (pp && !pop_ok)  exp_unf = 1'b1;
    push = ps; pop = pp; din = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0;
    chk("valid", 32'(valid), 32'(pop_ok));
    chk("dout", 32'(dout), 32'(exp_dout));
    chk_flags();
  endtask

  // Assert clr between edges and check outputs before any edge arrives.
  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    #1;
    q.delete();
    exp_dout = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk_flags();
    #1 clr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    clr = 1'b1; push = 1'b0; pop = 1'b0; din = 8'h00;
    exp_dout = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0;
    #12 clr = 1'b0;
    @(posedge clk); #1;

    // Reset then idle
    step(1, 0, 8'h99);
    do_clr();
    step(0, 0, 8'h00);

    // Arrival order
    step(1, 0, 8'h11); step(1, 0, 8'h22); step(1, 0, 8'h33);
    step(0, 1, 8'h00); chk("order0", 32'(dout), 32'h11);
    step(0, 1, 8'h00); chk("order1", 32'(dout), 32'h22);
    step(0, 1, 8'h00); chk("order2", 32'(dout), 32'h33);
    chk("order_empty", 32'(empty), 32'h1);

    // Fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 8'(i));
      if (i == 5) chk("af_at_6", 32'(almost_full), 32'h1);
      if (i == 6) chk("not_full_at_7", 32'(full), 32'h0);
    end
    chk("full_at_8", 32'(full), 32'h1);
    step(1, 0, 8'hFF);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_count", 32'(count), 32'h8);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'h00);
      chk("drain", 32'(dout), 32'(i));
    end

    // Simultaneous push/pop at full
    do_clr();
    for (int i = 0; i < 8; i++) step(1, 0, 8'(i));
    step(1, 1, 8'hAA);
    chk("sim_dout", 32'(dout), 32'h00);
    chk("sim_count", 32'(count), 32'h8);
    chk("sim_full", 32'(full), 32'h1);
    chk("sim_no_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00);
    chk("sim_last", 32'(dout), 32'hAA);

    // Underflow and push+pop on empty
    step(0, 1, 8'h00);
    chk("unf_set", 32'(underflow), 32'h1);
    chk("unf_dout_held", 32'(dout), 32'hAA);
    step(1, 1, 8'h5A);
    chk("ep_count", 32'(count), 32'h1);
    chk("ep_valid", 32'(valid), 32'h0);
    step(0, 1, 8'h00);
    chk("ep_dout", 32'(dout), 32'h5A);

    // Pointer wrap with random traffic
    do_clr();
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 8'($urandom));

    // Mid-operation reset at count 5
    do_clr();
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i));
    chk("pre_clr_count", 32'(count), 32'h5);
    do_clr();
    step(1, 0, 8'h3C);
    step(0, 1, 8'h00);
    chk("post_clr_dout", 32'(dout), 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
